// File: rtl/cfglut_pkg.sv
// Shared types and sizes for the CFGLUT serial-load receiver.
// Table geometry, deframer state encoding and the table word type.
package cfglut_pkg;

  localparam int CFGLUT_N    = 10;
  localparam int CFGLUT_BITS = 32;
  localparam int CFGLUT_AW   = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN
  } cfglut_rx_state_t;

  typedef logic [31:0] cfglut_table_t;

endpackage

// File: rtl/cfglut_lut_cell.sv
// One 32-entry, 5-input lookup table with a registered output.
// Ports: clk/reset, commit strobe, shadow word, 5-bit address,
// registered lut_out bit and the live table (tbl) for readback.
module cfglut_lut_cell
  import cfglut_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 commit,
  input  cfglut_table_t        shadow,
  input  logic [CFGLUT_AW-1:0] addr,
  output logic                 lut_out,
  output cfglut_table_t        tbl
);

  cfglut_table_t active_q, active_d;
  logic          lut_out_q, lut_out_d;

  always_comb begin
    active_d  = active_q;
    if (commit) active_d = shadow;
    // Lookup reads the table as it stood before this edge.
    lut_out_d = active_q[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= '0;
      lut_out_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      lut_out_q <= lut_out_d;
    end
  end

  assign lut_out = lut_out_q;
  assign tbl     = active_q;

endmodule

// File: rtl/cfglut_bank_rx.sv
// Serial CFGLUT receiver: deframes MSB-first 32-bit frames on CDI/CE
// and atomically commits them into N_LUT registered lookup tables.
// Ports: clk, reset (sync, active-high), CDI, CE[N_LUT-1:0], lut_in,
// lut_out, load_done/frame_err pulses, rb_sel/rb_table readback.
// Macro CFGLUT_RX_READBACK_EN builds the registered readback mux;
// without it rb_table is tied to 0 and rb_sel is ignored.
module cfglut_bank_rx
  import cfglut_pkg::*;
#(
  parameter int N_LUT    = CFGLUT_N,
  parameter int LUT_BITS = CFGLUT_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   CDI,
  input  logic [N_LUT-1:0]       CE,
  input  logic [5*N_LUT-1:0]     lut_in,
  output logic [N_LUT-1:0]       lut_out,
  output logic                   load_done,
  output logic                   frame_err,
  input  logic [3:0]             rb_sel,
  output logic [LUT_BITS-1:0]    rb_table
);

  localparam logic [5:0] FULL = 6'(LUT_BITS);

  cfglut_rx_state_t state_q, state_d;
  logic [5:0]       count_q, count_d;
  cfglut_table_t    shadow_q, shadow_d;
  logic [N_LUT-1:0] mask_q, mask_d;
  logic             load_done_q, load_done_d;
  logic             frame_err_q, frame_err_d;

  logic ce_any, ce_match, full;
  logic commit;

  assign ce_any   = |CE;
  assign ce_match = (CE == mask_q);
  assign full     = (count_q == FULL);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shadow_q    <= '0;
      mask_q      <= '0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shadow_q    <= shadow_d;
      mask_q      <= mask_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (ce_any) state_d = SHIFT;
      SHIFT: begin
        if (ce_match)     state_d = full ? DRAIN : SHIFT;
        else if (!ce_any) state_d = IDLE;
        else              state_d = DRAIN;
      end
      DRAIN: if (!ce_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and pulse outputs.
  always_comb begin
    shadow_d    = shadow_q;
    count_d     = count_q;
    mask_d      = mask_q;
    commit      = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce_any) begin
          mask_d   = CE;
          shadow_d = {{(LUT_BITS-1){1'b0}}, CDI};
          count_d  = 6'd1;
        end
      end
      SHIFT: begin
        unique case (1'b1)
          ce_match && !full: begin
            shadow_d = {shadow_q[LUT_BITS-2:0], CDI};
            count_d  = count_q + 6'd1;
          end
          ce_match && full: begin
            frame_err_d = 1'b1;
            count_d     = '0;
          end
          !ce_any && full: begin
            commit  = 1'b1;
            count_d = '0;
          end
          !ce_any && !full: begin
            frame_err_d = 1'b1;
            count_d     = '0;
          end
          ce_any && !ce_match: begin
            frame_err_d = 1'b1;
            count_d     = '0;
          end
          default: ;
        endcase
      end
      DRAIN:   ;
      default: ;
    endcase
    load_done_d = commit;
  end

  cfglut_table_t tables [N_LUT];

  for (genvar i = 0; i < N_LUT; i++) begin : g_cell
    cfglut_lut_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .commit  (commit & mask_q[i]),
      .shadow  (shadow_q),
      .addr    (lut_in[5*i +: 5]),
      .lut_out (lut_out[i]),
      .tbl     (tables[i])
    );
  end

`ifdef CFGLUT_RX_READBACK_EN
  cfglut_table_t rb_table_q, rb_table_d;

  always_comb begin
    rb_table_d = '0;
    if (rb_sel < 4'(N_LUT)) rb_table_d = tables[rb_sel];
  end

  always_ff @(posedge clk) begin
    if (reset) rb_table_q <= '0;
    else       rb_table_q <= rb_table_d;
  end

  assign rb_table = rb_table_q;
`else
  logic [N_LUT*LUT_BITS-1:0] unused_tables;

  for (genvar j = 0; j < N_LUT; j++) begin : g_unused
    assign unused_tables[j*LUT_BITS +: LUT_BITS] = tables[j];
  end

  logic unused_rb;
  assign unused_rb = ^{rb_sel, unused_tables};
  assign rb_table  = '0;
`endif

  assign load_done = load_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cfglut_bank_rx.sv
// Directed self-checking bench for cfglut_bank_rx.
// Frames, broadcast, error paths, reset mid-frame, readback.
module tb_cfglut_bank_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        CDI;
  logic [9:0]  CE;
  logic [49:0] lut_in;
  logic [9:0]  lut_out;
  logic        load_done;
  logic        frame_err;
  logic [3:0]  rb_sel;
  logic [31:0] rb_table;

  int nchk = 0;
  int nerr = 0;
  int ld_cnt = 0;
  int fe_cnt = 0;

  always #5 clk = ~clk;

  cfglut_bank_rx dut (
    .clk       (clk),
    .reset     (reset),
    .CDI       (CDI),
    .CE        (CE),
    .lut_in    (lut_in),
    .lut_out   (lut_out),
    .load_done (load_done),
    .frame_err (frame_err),
    .rb_sel    (rb_sel),
    .rb_table  (rb_table)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (load_done) ld_cnt++;
    if (frame_err) fe_cnt++;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic shift_bits(input logic [31:0] data,
                            input logic [9:0] m,
                            input int n);
    for (int i = 0; i < n; i++) begin
      CE  = m;
      CDI = (i < 32) ? data[31-i] : 1'b1;
      tick();
    end
  endtask

  function automatic logic [49:0] all_addr(input logic [4:0] a);
    return {10{a}};
  endfunction

  task automatic look(input logic [4:0] a);
    lut_in = all_addr(a);
    tick();
  endtask

  logic [31:0] rb_exp;

  initial begin
    reset  = 1'b1;
    CDI    = 1'b0;
    CE     = '0;
    lut_in = '0;
    rb_sel = '0;
    repeat (3) tick();
    chk("rst_lut_out", 32'(lut_out), 32'h0);
    chk("rst_load_done", 32'(load_done), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_rb_table", rb_table, 32'h0);
    reset = 1'b0;
    tick();

    // Single load into LUT 3.
    ld_cnt = 0; fe_cnt = 0;
    shift_bits(32'hDEADBEEF, 10'h008, 32);
    CE = '0;
    tick();
    chk("single_ld_pulse", 32'(load_done), 32'h1);
    tick();
    chk("single_ld_low", 32'(load_done), 32'h0);
    look(5'd0);
    chk("single_a0", 32'(lut_out), 32'h008);
    look(5'd4);
    chk("single_a4", 32'(lut_out), 32'h000);
    look(5'd5);
    chk("single_a5", 32'(lut_out), 32'h008);
    look(5'd31);
    chk("single_a31", 32'(lut_out), 32'h008);
    chk("single_ld_cnt", 32'(ld_cnt), 32'd1);
    chk("single_fe_cnt", 32'(fe_cnt), 32'd0);

    // Broadcast to all tables, back-to-back after a lookup.
    ld_cnt = 0; fe_cnt = 0;
    shift_bits(32'h80000000, 10'h3FF, 32);
    CE = '0;
    tick();
    chk("bcast_ld_pulse", 32'(load_done), 32'h1);
    look(5'd31);
    chk("bcast_a31", 32'(lut_out), 32'h3FF);
    look(5'd0);
    chk("bcast_a0", 32'(lut_out), 32'h000);
    rb_sel = 4'd7;
    tick();
`ifdef CFGLUT_RX_READBACK_EN
    rb_exp = 32'h80000000;
`else
    rb_exp = 32'h0;
`endif
    chk("bcast_rb7", rb_table, rb_exp);
    rb_sel = 4'd12;
    tick();
    chk("rb_out_of_range", rb_table, 32'h0);
    chk("bcast_ld_cnt", 32'(ld_cnt), 32'd1);

    // Short frame: 31 bits, LUT 3 must keep 0x80000000.
    ld_cnt = 0; fe_cnt = 0;
    shift_bits(32'h12345678, 10'h008, 31);
    CE = '0;
    tick();
    chk("short_fe_pulse", 32'(frame_err), 32'h1);
    chk("short_no_ld", 32'(load_done), 32'h0);
    look(5'd31);
    chk("short_keep_a31", 32'(lut_out), 32'h3FF);
    look(5'd3);
    chk("short_keep_a3", 32'(lut_out), 32'h000);
    chk("short_fe_cnt", 32'(fe_cnt), 32'd1);
    chk("short_ld_cnt", 32'(ld_cnt), 32'd0);

    // Overrun: 33 CE-high cycles on LUT 0.
    ld_cnt = 0; fe_cnt = 0;
    shift_bits(32'hFFFFFFFF, 10'h001, 32);
    chk("ovr_fe_early", 32'(frame_err), 32'h0);
    shift_bits(32'hFFFFFFFF, 10'h001, 1);
    chk("ovr_fe_pulse", 32'(frame_err), 32'h1);
    CE = '0;
    tick();
    chk("ovr_fe_low", 32'(frame_err), 32'h0);
    chk("ovr_no_ld", 32'(load_done), 32'h0);
    look(5'd0);
    chk("ovr_keep_a0", 32'(lut_out), 32'h000);
    shift_bits(32'h00000001, 10'h001, 32);
    CE = '0;
    tick();
    chk("ovr_next_ld", 32'(load_done), 32'h1);
    look(5'd0);
    chk("ovr_next_a0", 32'(lut_out), 32'h001);
    chk("ovr_fe_cnt", 32'(fe_cnt), 32'd1);
    chk("ovr_ld_cnt", 32'(ld_cnt), 32'd1);

    // Mask change mid-frame: 001 for 10 cycles, then 002.
    ld_cnt = 0; fe_cnt = 0;
    shift_bits(32'h0, 10'h001, 10);
    shift_bits(32'h0, 10'h002, 1);
    chk("mchg_fe_pulse", 32'(frame_err), 32'h1);
    shift_bits(32'hFFFFFFFF, 10'h002, 32);
    CE = '0;
    tick();
    chk("mchg_no_ld", 32'(load_done), 32'h0);
    look(5'd0);
    chk("mchg_a0", 32'(lut_out), 32'h001);
    look(5'd31);
    chk("mchg_a31", 32'(lut_out), 32'h3FE);
    chk("mchg_fe_cnt", 32'(fe_cnt), 32'd1);
    chk("mchg_ld_cnt", 32'(ld_cnt), 32'd0);

    // Reset after 16 shifts; tables cleared, no pulses.
    ld_cnt = 0; fe_cnt = 0;
    shift_bits(32'hFFFFFFFF, 10'h004, 16);
    CE = '0;
    reset = 1'b1;
    tick();
    chk("rmid_lut_out", 32'(lut_out), 32'h0);
    reset = 1'b0;
    look(5'd31);
    chk("rmid_a31", 32'(lut_out), 32'h000);
    look(5'd0);
    chk("rmid_a0", 32'(lut_out), 32'h000);
    chk("rmid_pulses", 32'(ld_cnt + fe_cnt), 32'd0);
    shift_bits(32'hAAAAAAAA, 10'h004, 32);
    CE = '0;
    tick();
    chk("rmid_ld", 32'(load_done), 32'h1);
    look(5'd31);
    chk("rmid_new_a31", 32'(lut_out), 32'h004);
    look(5'd0);
    chk("rmid_new_a0", 32'(lut_out), 32'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
